// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and counter sizing.
// Used by both the transmitter and the receiver so the two stay in lockstep.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int IDX_W     = $clog2(DATA_BITS);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_PARITY  = 3'd3;
    localparam logic [2:0] S_STOP    = 3'd4;
    localparam logic [2:0] S_CLEANUP = 3'd5;

    // Width of a counter that must reach clks_per_bit-1; never narrower than one bit.
    function automatic int cnt_width(input int clks_per_bit);
        return (clks_per_bit > 2) ? $clog2(clks_per_bit) : 1;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and strobes o_Bit_End on the last count.
// i_Clear holds the count at zero so a new bit always starts from a full period.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic i_Clock,
    input  logic i_Rst_L,
    input  logic i_Clear,
    output logic o_Bit_End
);

    localparam int              CW   = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (i_Clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_Bit_End = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Every output is a flop loaded from next-state decode, so the TX pin never glitches.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       i_Clock,
    input  logic       i_Rst_L,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Ready,
    output logic       o_Tx_Active,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Done,
    output logic [2:0] o_Tx_State
);

    logic [2:0]           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 serial_q, serial_d;
    logic                 active_q, active_d;
    logic                 done_q, done_d;
    logic                 ready_q, ready_d;
    logic                 bit_end;
    logic                 timer_clr;
    logic                 parity_bit;

    // The timer only runs while a bit is on the line.
    assign timer_clr = (state_q == S_IDLE) || (state_q == S_CLEANUP);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .i_Clock  (i_Clock),
        .i_Rst_L  (i_Rst_L),
        .i_Clear  (timer_clr),
        .o_Bit_End(bit_end)
    );

    assign parity_bit = (^data_q) ^ (PARITY_ODD != 0);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (i_Tx_DV) begin
                    data_d  = i_Tx_Byte;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                        idx_d   = '0;
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                // idx_q doubles as the stop-bit index.
                if (bit_end) begin
                    if (idx_q == IDX_W'(STOP_BITS - 1)) begin
                        idx_d   = '0;
                        state_d = S_CLEANUP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_CLEANUP: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        case (state_d)
            S_START:  serial_d = 1'b0;
            S_DATA:   serial_d = data_d[idx_d];
            S_PARITY: serial_d = parity_bit;
            default:  serial_d = 1'b1;
        endcase
        active_d = (state_d == S_START) || (state_d == S_DATA) ||
                   (state_d == S_PARITY) || (state_d == S_STOP);
        done_d   = (state_d == S_CLEANUP);
        ready_d  = (state_d == S_IDLE);
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            data_q   <= '0;
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            serial_q <= serial_d;
            active_q <= active_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign o_Tx_Serial = serial_q;
    assign o_Tx_Active = active_q;
    assign o_Tx_Done   = done_q;
    assign o_Tx_Ready  = ready_q;
    assign o_Tx_State  = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three configurations side by side, a line-level reference model
// and a per-instance monitor that decodes each frame and compares it to the expected queue.
module tb_uart_tx;

    localparam int NI = 3;

    // Instance 0: no parity, 1 stop; 1: even parity, 1 stop; 2: odd parity, 2 stops.
    function automatic int cpb_of(input int g); return (g == 2) ? 5 : 4; endfunction
    function automatic int pe_of(input int g);  return (g == 0) ? 0 : 1; endfunction
    function automatic int po_of(input int g);  return (g == 2) ? 1 : 0; endfunction
    function automatic int sb_of(input int g);  return (g == 2) ? 2 : 1; endfunction

    function automatic int frame_len(input int g);
        return 1 + 8 + pe_of(g) + sb_of(g);
    endfunction

    // Line level of bit k of the frame carrying byte b.
    function automatic logic frame_bit(input int g, input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (pe_of(g) != 0 && k == 9) return ((($countones(b) + po_of(g)) % 2) == 1);
        return 1'b1;
    endfunction

    logic        clk;
    logic        rst_n;
    logic        dv      [NI];
    logic [7:0]  tx_byte [NI];
    logic        ready   [NI];
    logic        active  [NI];
    logic        serial  [NI];
    logic        done    [NI];
    logic [2:0]  state   [NI];

    int unsigned cyc;
    bit          mon_en;
    int          n_checks;
    int          n_fail;

    logic [7:0]  exp_q [NI][$];
    int unsigned exp_t [NI][$];
    int          pushed  [NI];
    int          frames  [NI];
    int          aborted [NI];
    int          stray   [NI];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        uart_tx #(
            .CLKS_PER_BIT(cpb_of(g)),
            .PARITY_EN   (pe_of(g)),
            .PARITY_ODD  (po_of(g)),
            .STOP_BITS   (sb_of(g))
        ) dut (
            .i_Clock    (clk),
            .i_Rst_L    (rst_n),
            .i_Tx_DV    (dv[g]),
            .i_Tx_Byte  (tx_byte[g]),
            .o_Tx_Ready (ready[g]),
            .o_Tx_Active(active[g]),
            .o_Tx_Serial(serial[g]),
            .o_Tx_Done  (done[g]),
            .o_Tx_State (state[g])
        );
    end

    task automatic check(input bit ok, input string name, input int g,
                         input int unsigned act, input int unsigned exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s inst=%0d actual=0x%0h expected=0x%0h", name, g, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int g, input logic [7:0] b, input bit hold, output int unsigned acc);
        int n;
        acc = 0;
        dv[g]      = 1'b1;
        tx_byte[g] = b;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ready[g] !== 1'b1 && n < 400);
        if (ready[g] !== 1'b1) begin
            check(1'b0, "send_timeout", g, 32'(n), 32'd400);
            dv[g] = 1'b0;
            @(posedge clk);
            #1;
            return;
        end
        acc = cyc + 1;
        exp_q[g].push_back(b);
        exp_t[g].push_back(acc);
        pushed[g]++;
        @(posedge clk);
        #1;
        if (!hold) begin
            dv[g]      = 1'b0;
            tx_byte[g] = 8'($urandom);
        end
    endtask

    task automatic rand_run(input int g);
        int gap [8];
        int unsigned a;
        for (int i = 0; i < 8; i++) gap[i] = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 20);
        for (int i = 0; i < 8; i++) begin
            wait_cycles(gap[i]);
            send(g, 8'($urandom), (i < 7) && (gap[(i + 1) % 8] == 0), a);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    for (genvar g = 0; g < NI; g++) begin : g_mon
        initial begin
            logic [7:0]  eb;
            logic [7:0]  rx;
            int unsigned t0;
            int unsigned at;
            int          nb;
            int          cp;
            bit          ok;
            bit          abort;
            logic        fbit;
            nb = frame_len(g);
            cp = cpb_of(g);
            forever begin
                @(negedge clk);
                if (!mon_en || !rst_n) continue;
                if (serial[g] !== 1'b0) begin
                    if (ready[g] !== 1'b1 || active[g] !== 1'b0 || done[g] !== 1'b0) stray[g]++;
                    continue;
                end
                t0 = cyc;
                if (exp_q[g].size() == 0) begin
                    check(1'b0, "unexpected_frame", g, t0, 32'd0);
                    for (int w = 0; w < 200 && serial[g] !== 1'b1; w++) @(negedge clk);
                    continue;
                end
                eb = exp_q[g][0];
                at = exp_t[g][0];
                check(t0 == at, "start_cycle", g, t0, at);
                abort = 1'b0;
                rx = 8'h00;
                for (int k = 0; k < nb && !abort; k++) begin
                    ok = 1'b1;
                    fbit = frame_bit(g, eb, k);
                    for (int c = 0; c < cp; c++) begin
                        if (k != 0 || c != 0) @(negedge clk);
                        if (!rst_n) begin
                            abort = 1'b1;
                            break;
                        end
                        if (serial[g] !== fbit || active[g] !== 1'b1 ||
                            ready[g] !== 1'b0 || done[g] !== 1'b0) ok = 1'b0;
                        if (c == cp / 2 && k >= 1 && k <= 8) rx[k-1] = serial[g];
                    end
                    if (!abort) check(ok, $sformatf("bit_hold_k%0d", k), g, 32'(ok), 32'd1);
                end
                if (abort) begin
                    void'(exp_q[g].pop_front());
                    void'(exp_t[g].pop_front());
                    aborted[g]++;
                    continue;
                end
                @(negedge clk);
                check(ready[g] === 1'b0 && done[g] === 1'b1 && active[g] === 1'b0 && serial[g] === 1'b1,
                      "done_pulse", g, 32'({ready[g], done[g], active[g], serial[g]}), 32'h5);
                @(negedge clk);
                check(ready[g] === 1'b1 && done[g] === 1'b0 && active[g] === 1'b0 && serial[g] === 1'b1,
                      "ready_back", g, 32'({ready[g], done[g], active[g], serial[g]}), 32'h9);
                check(rx == eb, "rx_byte", g, 32'(rx), 32'(eb));
                void'(exp_q[g].pop_front());
                void'(exp_t[g].pop_front());
                frames[g]++;
            end
        end
    end

    task automatic report();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog inst=0 actual=timeout expected=finish");
        n_checks++;
        n_fail++;
        report();
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        int unsigned a1, a2, a3;
        int n;
        n_checks = 0;
        n_fail   = 0;
        mon_en   = 1'b0;
        rst_n    = 1'b0;
        for (int i = 0; i < NI; i++) begin
            dv[i] = 1'b0;
            tx_byte[i] = 8'h00;
            pushed[i] = 0;
            frames[i] = 0;
            aborted[i] = 0;
            stray[i] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++)
            check(ready[i] === 1'b1 && done[i] === 1'b0 && active[i] === 1'b0 && serial[i] === 1'b1,
                  "reset_state", i, 32'({ready[i], done[i], active[i], serial[i]}), 32'h9);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        wait_cycles(3);

        // Basic frame plus parity and two-stop-bit frames in parallel.
        fork
            send(0, 8'hA5, 1'b0, a1);
            begin
                send(1, 8'h07, 1'b0, a2);
            end
            begin
                send(2, 8'h07, 1'b0, a3);
                send(2, 8'hFF, 1'b0, a3);
            end
        join
        wait_cycles(70);

        // Back-to-back with DV held, then an ignored DV pulse while busy.
        send(0, 8'h00, 1'b1, a1);
        send(0, 8'h55, 1'b0, a2);
        check(a2 == a1 + 32'(frame_len(0) * cpb_of(0) + 2), "b2b_gap", 0, a2 - a1,
              32'(frame_len(0) * cpb_of(0) + 2));
        wait_cycles(5);
        dv[0] = 1'b1;
        tx_byte[0] = 8'h12;
        @(negedge clk);
        check(ready[0] === 1'b0, "busy_not_ready", 0, 32'(ready[0]), 32'd0);
        @(posedge clk);
        #1;
        dv[0] = 1'b0;
        wait_cycles(60);

        // Reset during data bit 3 of 0x3C.
        send(0, 8'h3C, 1'b0, a1);
        n = 0;
        while (cyc != a1 + 16 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(cyc == a1 + 16, "reach_bit3", 0, cyc, a1 + 16);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check(ready[0] === 1'b1 && done[0] === 1'b0 && active[0] === 1'b0 && serial[0] === 1'b1,
              "reset_mid_frame", 0, 32'({ready[0], done[0], active[0], serial[0]}), 32'h9);
        wait_cycles(2);

        // Recovery and loopback byte set.
        send(0, 8'h81, 1'b0, a1);
        send(0, 8'h00, 1'b0, a1);
        send(0, 8'hFF, 1'b0, a1);
        send(0, 8'h5A, 1'b0, a1);
        send(0, 8'hC3, 1'b0, a1);
        wait_cycles(60);

        // Randomized traffic on all instances.
        fork
            rand_run(0);
            rand_run(1);
            rand_run(2);
        join
        wait_cycles(90);

        for (int i = 0; i < NI; i++) begin
            check(exp_q[i].size() == 0, "queue_drained", i, 32'(exp_q[i].size()), 32'd0);
            check(aborted[i] == ((i == 0) ? 1 : 0), "aborted_frames", i, 32'(aborted[i]),
                  (i == 0) ? 32'd1 : 32'd0);
            check(frames[i] + aborted[i] == pushed[i], "frame_count", i,
                  32'(frames[i] + aborted[i]), 32'(pushed[i]));
            check(stray[i] == 0, "idle_outputs", i, 32'(stray[i]), 32'd0);
        end
        report();
        $finish;
    end

endmodule
